// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: one VRAM write port shared by the clear engine, the host port and the renderer stream.
// Define VRAM_ARB_STATS_EN to add saturating host/renderer/drop counters.
module vram_write_arbiter #(
  parameter int DW = 24,
  parameter int AW = 16,
  parameter int PIXELS = 53760,
  parameter logic [DW-1:0] FILL = 24'h000000
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          host_req,
  input  logic [AW-1:0] host_adr,
  input  logic [DW-1:0] host_d,
  output logic          host_ack,
  input  logic          rend_valid,
  input  logic [AW-1:0] rend_adr,
  input  logic [DW-1:0] rend_d,
  output logic          rend_ready,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]   host_cnt,
  output logic [15:0]   rend_cnt,
  output logic [15:0]   drop_cnt,
`endif
  output logic          vram_we,
  output logic [AW-1:0] vram_wadr,
  output logic [DW-1:0] vram_d
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [AW:0] LIM = (AW+1)'(PIXELS);
  localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);
  state_t state;
  logic [AW-1:0] clr_adr;
  logic last_host;
  logic arb, grant, in_range;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_d;
  // strobes see only the handshake bits, never the address/data buses
  always_comb begin
    arb = state == IDLE && !clr_start;
    host_ack = arb && host_req && (!rend_valid || !last_host);
    rend_ready = arb && rend_valid && (!host_req || last_host);
    grant = host_ack || rend_ready;
    g_adr = host_ack ? host_adr : rend_adr;
    g_d = host_ack ? host_d : rend_d;
    in_range = {1'b0, g_adr} < LIM;
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= IDLE;
      clr_adr <= '0;
      clr_busy <= 1'b0;
      last_host <= 1'b0;
      vram_we <= 1'b0;
      vram_wadr <= '0;
      vram_d <= '0;
    end else if (state == CLEAR) begin
      vram_we <= 1'b1;
      vram_wadr <= clr_adr;
      vram_d <= FILL;
      clr_adr <= clr_adr + 1'b1;
      if (clr_adr == LAST) begin
        state <= IDLE;
        clr_busy <= 1'b0;
      end
    end else if (clr_start) begin
      state <= CLEAR;
      clr_adr <= '0;
      clr_busy <= 1'b1;
      vram_we <= 1'b0;
    end else begin
      vram_we <= grant && in_range;
      if (grant) last_host <= host_ack;
      if (grant && in_range) begin
        vram_wadr <= g_adr;
        vram_d <= g_d;
      end
    end
`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      host_cnt <= '0;
      rend_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (host_ack && ~&host_cnt) host_cnt <= host_cnt + 1'b1;
      if (rend_ready && ~&rend_cnt) rend_cnt <= rend_cnt + 1'b1;
      if (grant && !in_range && ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
    end
`endif
endmodule
